// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types and constants for the traffic light controller:
//                state encoding, one-hot lamp codes and dwell-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Width of the per-phase dwell counter; all dwell parameters fit in it.
  localparam int DWELL_W = 8;

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    WALK      = 3'd6
  } state_e;

  // Lamp bundles are {red, yellow, green}, exactly one bit set.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_light_fsm_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Counts ticks spent in the current phase. done is asserted
//                combinationally on the tick that completes the phase, i.e.
//                when tick=1 and the count equals limit-1.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-high reset (count -> 0)
//                clr   - restart the count (phase change)
//                tick  - timebase pulse, one count per cycle it is high
//                limit - phase length in ticks (1..255)
//                done  - phase completes on this edge
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer
  import traffic_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               tick,
  input  logic [DWELL_W-1:0] limit,
  output logic               done
);

  localparam logic [DWELL_W-1:0] C_ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  assign done = tick && (count_q == (limit - C_ONE));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : dwell_timer
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_fsm
//  Description : Two-way intersection controller with all-red clearance
//                phases and an optional pedestrian walk phase served once
//                per round after east-west yellow.
//  Ports       : clk         - rising-edge clock
//                reset       - synchronous active-high reset
//                tick        - timebase pulse, one tick per high cycle
//                ped_req     - pedestrian request (single-cycle pulse enough)
//                ns_light    - north-south lamps {red,yellow,green}
//                ew_light    - east-west lamps {red,yellow,green}
//                walk        - pedestrian walk lamp
//                ped_pending - request latched, not yet served
//                state       - current state encoding (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 8,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned RED_TICKS    = 1,
  parameter int unsigned WALK_TICKS   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  state_e             state_q;
  state_e             state_d;
  logic               ped_pending_q;
  logic               ped_pending_d;
  logic [DWELL_W-1:0] limit;
  logic               advance;

  // Dwell length of the phase currently being timed.
  always_comb begin
    limit = DWELL_W'(RED_TICKS);
    unique case (state_q)
      NS_GREEN,  EW_GREEN:  limit = DWELL_W'(GREEN_TICKS);
      NS_YELLOW, EW_YELLOW: limit = DWELL_W'(YELLOW_TICKS);
      WALK:                 limit = DWELL_W'(WALK_TICKS);
      default:              limit = DWELL_W'(RED_TICKS);
    endcase
  end

  // Every advance is a state change, so it doubles as the counter restart.
  dwell_timer u_dwell_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (advance),
    .tick  (tick),
    .limit (limit),
    .done  (advance)
  );

  always_comb begin
    state_d       = state_q;
    ped_pending_d = ped_pending_q;

    if (ped_req) begin
      ped_pending_d = 1'b1;
    end

    if (advance) begin
      unique case (state_q)
        ALLRED_A:  state_d = NS_GREEN;
        NS_GREEN:  state_d = NS_YELLOW;
        NS_YELLOW: state_d = ALLRED_B;
        ALLRED_B:  state_d = EW_GREEN;
        EW_GREEN:  state_d = EW_YELLOW;
        EW_YELLOW: state_d = ped_pending_q ? WALK : ALLRED_A;
        WALK:      state_d = ALLRED_A;
        default:   state_d = ALLRED_A;
      endcase
    end

    // Entering WALK serves the request; a request arriving on that same
    // edge is considered served by this walk too.
    if ((state_d == WALK) && (state_q != WALK)) begin
      ped_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ALLRED_A;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Moore lamp decode from the state register only.
  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    walk     = 1'b0;
    unique case (state_q)
      NS_GREEN:  ns_light = LAMP_GREEN;
      NS_YELLOW: ns_light = LAMP_YELLOW;
      EW_GREEN:  ew_light = LAMP_GREEN;
      EW_YELLOW: ew_light = LAMP_YELLOW;
      WALK:      walk     = 1'b1;
      default:   walk     = 1'b0;
    endcase
  end

  assign ped_pending = ped_pending_q;
  assign state       = state_q;

endmodule : traffic_light_fsm
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_fsm
//  Description : Directed self-checking bench for traffic_light_fsm with
//                default parameters (green 8, yellow 3, red 1, walk 5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .ped_req     (ped_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .state       (state)
  );

  // Expected state n ticks into a round without walk (round = 24 ticks).
  function automatic logic [2:0] round_state(int n);
    int m = n % 24;
    if (m == 0)  return ALLRED_A;
    if (m <= 8)  return NS_GREEN;
    if (m <= 11) return NS_YELLOW;
    if (m == 12) return ALLRED_B;
    if (m <= 20) return EW_GREEN;
    return EW_YELLOW;
  endfunction

  function automatic logic [2:0] exp_ns(logic [2:0] s);
    if (s == NS_GREEN)  return 3'b001;
    if (s == NS_YELLOW) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_ew(logic [2:0] s);
    if (s == EW_GREEN)  return 3'b001;
    if (s == EW_YELLOW) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic exp_walk(logic [2:0] s);
    return (s == WALK);
  endfunction

  // Lamp safety, evaluated every cycle on the inactive edge.
  always @(negedge clk) begin
    n_checks++;
    if ((ns_light != 3'b100 && ew_light != 3'b100) ||
        !$onehot(ns_light) || !$onehot(ew_light)) begin
      n_fail++;
      $display("FAIL lamp_safety @%0t: ns=%b ew=%b, required one-hot and at least one red",
               $time, ns_light, ew_light);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({state, ns_light, ew_light, walk, ped_pending} !==
        {3'(ALLRED_A), 3'b100, 3'b100, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d ns=%b ew=%b walk=%b pend=%b, expected state=%0d ns=100 ew=100 walk=0 pend=0",
               state, ns_light, ew_light, walk, ped_pending, ALLRED_A);
    end
    // Advance into NS_GREEN, then hold without tick.
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (state !== 3'(NS_GREEN)) begin
      n_fail++;
      $display("FAIL hold_no_tick: got state=%0d expected %0d", state, NS_GREEN);
    end
    // Reset dominates tick and ped_req.
    reset   = 1'b1;
    tick    = 1'b1;
    ped_req = 1'b1;
    step();
    reset   = 1'b0;
    tick    = 1'b0;
    ped_req = 1'b0;
    n_checks++;
    if ({state, ped_pending} !== {3'(ALLRED_A), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_override: got state=%0d pend=%b, expected state=%0d pend=0",
               state, ped_pending, ALLRED_A);
    end
  endtask

  task automatic test_full_round();
    logic [2:0] e;
    do_reset();
    tick = 1'b1;
    for (int n = 1; n <= 49; n++) begin
      step();
      e = round_state(n);
      n_checks++;
      if ({state, ns_light, ew_light, walk, ped_pending} !==
          {e, exp_ns(e), exp_ew(e), exp_walk(e), 1'b0}) begin
        n_fail++;
        $display("FAIL full_round n=%0d: got state=%0d ns=%b ew=%b walk=%b pend=%b, expected state=%0d ns=%b ew=%b walk=%b pend=0",
                 n, state, ns_light, ew_light, walk, ped_pending, e, exp_ns(e), exp_ew(e), exp_walk(e));
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_slow_tick();
    int         ticks = 0;
    logic [2:0] e;
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      tick = ((c % 4) == 0);
      step();
      if (tick) ticks++;
      tick = 1'b0;
      e = round_state(ticks);
      n_checks++;
      if ({state, ns_light, ew_light} !== {e, exp_ns(e), exp_ew(e)}) begin
        n_fail++;
        $display("FAIL slow_tick c=%0d: got state=%0d ns=%b ew=%b, expected state=%0d ns=%b ew=%b",
                 c, state, ns_light, ew_light, e, exp_ns(e), exp_ew(e));
      end
    end
  endtask

  // Request in NS_GREEN gives a walk after EW_YELLOW; a request made during
  // WALK is served in the following round.
  task automatic test_ped_walk();
    logic [2:0] e;
    logic       ep;
    do_reset();
    tick = 1'b1;
    for (int n = 1; n <= 58; n++) begin
      ped_req = (n == 3) || (n == 26);
      step();
      ped_req = 1'b0;
      if (n < 24)       e = round_state(n);
      else if (n <= 28) e = WALK;
      else if (n <= 52) e = round_state(n - 29);
      else if (n <= 57) e = WALK;
      else              e = ALLRED_A;
      ep = (n >= 3 && n <= 23) || (n >= 26 && n <= 52);
      n_checks++;
      if ({state, ns_light, ew_light, walk, ped_pending} !==
          {e, exp_ns(e), exp_ew(e), exp_walk(e), ep}) begin
        n_fail++;
        $display("FAIL ped_walk n=%0d: got state=%0d ns=%b ew=%b walk=%b pend=%b, expected state=%0d ns=%b ew=%b walk=%b pend=%b",
                 n, state, ns_light, ew_light, walk, ped_pending, e, exp_ns(e), exp_ew(e), exp_walk(e), ep);
      end
    end
    tick = 1'b0;
  endtask

  // Repeated requests while pending and one on the WALK-entry edge yield a
  // single walk; the following round has none.
  task automatic test_ped_absorb();
    logic [2:0] e;
    logic       ep;
    do_reset();
    tick = 1'b1;
    for (int n = 1; n <= 54; n++) begin
      ped_req = (n == 2) || (n == 10) || (n == 15) || (n == 24);
      step();
      ped_req = 1'b0;
      if (n < 24)       e = round_state(n);
      else if (n <= 28) e = WALK;
      else              e = round_state(n - 29);
      ep = (n >= 2 && n <= 23);
      n_checks++;
      if ({state, walk, ped_pending} !== {e, exp_walk(e), ep}) begin
        n_fail++;
        $display("FAIL ped_absorb n=%0d: got state=%0d walk=%b pend=%b, expected state=%0d walk=%b pend=%b",
                 n, state, walk, ped_pending, e, exp_walk(e), ep);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_reset_in_walk();
    do_reset();
    tick = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      ped_req = (n == 2);
      step();
      ped_req = 1'b0;
    end
    n_checks++;
    if ({state, walk} !== {3'(WALK), 1'b1}) begin
      n_fail++;
      $display("FAIL walk_before_reset: got state=%0d walk=%b, expected state=%0d walk=1",
               state, walk, WALK);
    end
    reset   = 1'b1;
    ped_req = 1'b1;
    step();
    reset   = 1'b0;
    ped_req = 1'b0;
    n_checks++;
    if ({state, ns_light, ew_light, walk, ped_pending} !==
        {3'(ALLRED_A), 3'b100, 3'b100, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_in_walk: got state=%0d ns=%b ew=%b walk=%b pend=%b, expected state=%0d ns=100 ew=100 walk=0 pend=0",
               state, ns_light, ew_light, walk, ped_pending, ALLRED_A);
    end
    step();
    n_checks++;
    if ({state, ped_pending} !== {3'(NS_GREEN), 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_in_walk: got state=%0d pend=%b, expected state=%0d pend=0",
               state, ped_pending, NS_GREEN);
    end
    tick = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    test_reset();
    test_full_round();
    test_slow_tick();
    test_ped_walk();
    test_ped_absorb();
    test_reset_in_walk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_traffic_light_fsm
`default_nettype wire

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameter GREEN_TICKS, default 8, green dwell in ticks; legal range 1..255.
REQ-002 Parameter YELLOW_TICKS, default 3, yellow dwell in ticks; legal range 1..255.
REQ-003 Parameter RED_TICKS, default 1, all-red clearance dwell in ticks; legal range 1..255.
REQ-004 Parameter WALK_TICKS, default 5, pedestrian walk dwell in ticks; legal range 1..255.
REQ-005 clk  in  1  single clock for the whole block; all logic SHALL be clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 tick  in  1  timebase pulse from the roll counter; each clk cycle with tick=1 SHALL count as one tick.
REQ-008 ped_req  in  1  pedestrian request; a single-cycle pulse is sufficient.
REQ-009 ns_light  out  3  north-south lamps, one-hot {red,yellow,green}.
REQ-010 ew_light  out  3  east-west lamps, one-hot {red,yellow,green}.
REQ-011 walk  out  1  pedestrian walk lamp.
REQ-012 ped_pending  out  1  a pedestrian request is latched and not yet served.
REQ-013 state  out  3  current state encoding, for debug.

Function
REQ-014 States SHALL be ALLRED_A, NS_GREEN, NS_YELLOW, ALLRED_B, EW_GREEN, EW_YELLOW, WALK.
REQ-015 Sequence: ALLRED_A->NS_GREEN->NS_YELLOW->ALLRED_B->EW_GREEN->EW_YELLOW->(WALK if ped_pending else ALLRED_A); WALK->ALLRED_A.
REQ-016 An 8-bit dwell counter SHALL increment on each tick and reset to 0 on every state change.
REQ-017 The state SHALL advance on the clk edge where tick=1 and dwell==DUR-1, where DUR is that state's parameter (ALLRED_A/B use RED_TICKS).
REQ-018 Without tick the state and dwell counter SHALL hold indefinitely.
REQ-019 Lamps SHALL decode from the state register only (Moore outputs), changing in the same cycle as the state register.
REQ-020 ns_light=green in NS_GREEN, yellow in NS_YELLOW, red otherwise; ew_light likewise for EW_GREEN/EW_YELLOW.
REQ-021 walk=1 only in WALK; both directions SHALL show red in WALK, ALLRED_A and ALLRED_B.
REQ-022 Both directions SHALL never be non-red in the same cycle.
REQ-023 ped_req=1 SHALL set ped_pending on the next edge; ped_pending SHALL clear on the edge entering WALK.
REQ-024 A ped_req coincident with the WALK-entry edge SHALL be absorbed (ped_pending=0 after that edge).
REQ-025 A ped_req while in WALK SHALL set ped_pending, to be served in the next round.
REQ-026 Repeated ped_req while pending SHALL have no further effect (one walk per round).
REQ-027 With tick constant high and no requests, the full round SHALL be 24 cycles (1+8+3+1+8+3).

Reset
REQ-028 reset=1 SHALL force state=ALLRED_A, dwell=0, ped_pending=0 on the next edge, overriding tick and ped_req.
REQ-029 After reset: ns_light=ew_light=3'b100, walk=0, ped_pending=0.
REQ-030 Reset asserted mid-phase (including WALK) SHALL abort that phase and discard any pending request.

Structure
REQ-031 Package traffic_pkg SHALL hold the state enumeration/encodings, lamp one-hot constants and the dwell-counter width (8).
REQ-032 The dwell counter SHALL be a sub-module dwell_timer (inputs clk, reset, clr, tick, limit; output done).

Verification
REQ-033 Reset, tick=1 constantly -> NS green cycles 1..8, NS yellow 9..11, all-red 12, EW green 13..20, EW yellow 21..23, ALLRED_A 24, NS green again at 25.
REQ-034 tick pulsing every 4th cycle -> every phase lasts 4x its tick count; the state holds between ticks.
REQ-035 ped_req pulse during NS_GREEN -> ped_pending=1 next cycle; WALK follows EW_YELLOW for 5 ticks with walk=1 and both sides red, then ALLRED_A.
REQ-036 ped_req on the WALK-entry edge -> ped_pending=0 after WALK; the next round has no walk.
REQ-037 reset during WALK at tick 2 -> next cycle state=ALLRED_A, walk=0, ped_pending=0.
REQ-038 Assertion across all tests -> never both ns_light and ew_light non-red; lamps always one-hot.
